// File: rtl/regfile_trace.sv
// General-purpose register file (2 read / 1 write) with a delayed write-trace FIFO
// that releases each committed write to a consumer through a valid/ready handshake.
module regfile_trace #(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1,
    parameter int LOG_DEPTH = 16,
    parameter int LOG_DELAY = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [AW-1:0]               ra1,
    input  logic [AW-1:0]               ra2,
    output logic [DW-1:0]               rd1,
    output logic [DW-1:0]               rd2,
    input  logic [AW-1:0]               wa,
    input  logic [DW-1:0]               wd,
    input  logic                        we,
    input  logic [DW-1:0]               pc,
    output logic                        log_valid,
    input  logic                        log_ready,
    output logic [DW-1:0]               log_pc,
    output logic [AW-1:0]               log_addr,
    output logic [DW-1:0]               log_data,
    output logic [$clog2(LOG_DEPTH):0]  log_count,
    output logic [15:0]                 log_drops,
    output logic                        log_overflow,
    input  logic                        clear_overflow
);
    localparam int NREG = 2 ** AW;
    localparam int PW   = $clog2(LOG_DEPTH);
    localparam logic [PW:0]   FULL_COUNT = (PW+1)'(LOG_DEPTH);
    localparam logic [PW:0]   COUNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [DW-1:0] CNT_ONE    = DW'(1);
    localparam logic [DW-1:0] DELAY      = DW'(LOG_DELAY);

    logic [DW-1:0] rf [NREG];
    logic [DW-1:0] cnt;

    logic [DW-1:0] fifo_pc   [LOG_DEPTH];
    logic [AW-1:0] fifo_addr [LOG_DEPTH];
    logic [DW-1:0] fifo_data [LOG_DEPTH];
    logic [DW-1:0] fifo_ts   [LOG_DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   count;

    logic          wr_en;
    logic          full;
    logic          pop;
    logic          accept;
    logic          drop;
    logic [DW-1:0] age;

    always_comb begin
        rd1 = rf[ra1];
        if ((BYPASS != 0) && we && (wa == ra1)) rd1 = wd;
        if ((ZERO_REG != 0) && (ra1 == '0)) rd1 = '0;
    end

    always_comb begin
        rd2 = rf[ra2];
        if ((BYPASS != 0) && we && (wa == ra2)) rd2 = wd;
        if ((ZERO_REG != 0) && (ra2 == '0)) rd2 = '0;
    end

    assign wr_en = we && !((ZERO_REG != 0) && (wa == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wr_en) begin
            rf[wa] <= wd;
        end
    end

    // Age is a modular difference, so the free-running counter may wrap freely.
    assign age       = cnt - fifo_ts[rptr];
    assign full      = (count == FULL_COUNT);
    assign log_valid = (count != '0) && (age >= DELAY);
    assign pop       = log_valid && log_ready;
    assign accept    = we && (!full || pop);
    assign drop      = we && full && !pop;

    assign log_pc    = fifo_pc[rptr];
    assign log_addr  = fifo_addr[rptr];
    assign log_data  = fifo_data[rptr];
    assign log_count = count;

    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_pc[wptr]   <= pc;
            fifo_addr[wptr] <= wa;
            fifo_data[wptr] <= wd;
            fifo_ts[wptr]   <= cnt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
            if (accept) wptr <= wptr + PTR_ONE;
            if (pop)    rptr <= rptr + PTR_ONE;
            case ({accept, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // A drop in the same cycle as a clear leaves exactly that one drop recorded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            log_drops    <= '0;
            log_overflow <= 1'b0;
        end else if (drop) begin
            log_overflow <= 1'b1;
            if (clear_overflow)             log_drops <= 16'd1;
            else if (log_drops != 16'hFFFF) log_drops <= log_drops + 16'd1;
        end else if (clear_overflow) begin
            log_drops    <= '0;
            log_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_trace.sv
// Self-checking bench for regfile_trace: randomized traffic against a queue-based
// reference model of the register file and its delayed trace FIFO.
module tb_regfile_trace;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 16;
    localparam int DELAY = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] ra1, ra2, wa;
    logic [DW-1:0] rd1, rd2, wd, pc;
    logic          we, log_ready, clear_overflow;
    logic          log_valid, log_overflow;
    logic [DW-1:0] log_pc, log_data;
    logic [AW-1:0] log_addr;
    logic [4:0]    log_count;
    logic [15:0]   log_drops;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
        int unsigned ts;
    } rec_t;

    rec_t        mq[$];
    logic [31:0] mrf [32];
    int unsigned cyc;
    int          mdrops;
    bit          movf;

    always #5 clk = ~clk;

    regfile_trace #(.DW(DW), .AW(AW), .ZERO_REG(1), .BYPASS(1),
                    .LOG_DEPTH(DEPTH), .LOG_DELAY(DELAY)) dut (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .wa(wa), .wd(wd), .we(we), .pc(pc), .log_valid(log_valid),
        .log_ready(log_ready), .log_pc(log_pc), .log_addr(log_addr),
        .log_data(log_data), .log_count(log_count), .log_drops(log_drops),
        .log_overflow(log_overflow), .clear_overflow(clear_overflow)
    );

    function automatic logic [31:0] m_read(input logic [4:0] ra);
        if (ra == 0) return 32'h0;
        if (we && wa == ra) return wd;
        return mrf[ra];
    endfunction

    function automatic bit m_valid();
        if (mq.size() == 0) return 1'b0;
        return (cyc - mq[0].ts) >= DELAY;
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
        cyc = 0;
        mdrops = 0;
        movf = 1'b0;
    endtask

    // Advances the model by one clock using the inputs the DUT samples at this edge.
    task automatic tick();
        rec_t r;
        bit   p;
        bit   d;
        p = m_valid() && log_ready;
        d = 1'b0;
        if (we && wa != 0) mrf[wa] = wd;
        if (p) mq.delete(0);
        if (we) begin
            if (mq.size() < DEPTH) begin
                r.pc = pc; r.addr = wa; r.data = wd; r.ts = cyc;
                mq.push_back(r);
            end else begin
                d = 1'b1;
            end
        end
        if (d) begin
            movf = 1'b1;
            mdrops = clear_overflow ? 1 : (mdrops < 65535 ? mdrops + 1 : 65535);
        end else if (clear_overflow) begin
            movf = 1'b0;
            mdrops = 0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (log_valid !== 1'b0 || log_count !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_fifo: valid=%b count=%0d expected valid=0 count=0", log_valid, log_count);
        end
        vectors++;
        if (log_drops !== 16'd0 || log_overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_drops: drops=%0d ovf=%b expected 0/0", log_drops, log_overflow);
        end
        for (int i = 0; i < 4; i++) begin
            ra1 = AW'($urandom); ra2 = AW'($urandom);
            #1;
            vectors++;
            if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
                miscompares++;
                $display("[TB] FAIL reset_rf: rd1=%h rd2=%h expected 0", rd1, rd2);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_bypass_rw();
        log_ready = 1'b1;
        we = 1'b1; wa = 5'd3; wd = 32'hDEADBEEF; pc = 32'h1000; ra1 = 5'd3; ra2 = 5'd0;
        #1;
        vectors++;
        if (rd1 !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL bypass_rd1: got %h expected deadbeef", rd1);
        end
        tick();
        we = 1'b0;
        #1;
        vectors++;
        if (rd1 !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL stored_rd1: got %h expected deadbeef", rd1);
        end
        we = 1'b1; wa = 5'd0; wd = 32'h12345678; pc = 32'h1004;
        #1;
        vectors++;
        if (rd2 !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL zero_bypass_rd2: got %h expected 0", rd2);
        end
        tick();
        we = 1'b0;
        #1;
        vectors++;
        if (rd2 !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL zero_stored_rd2: got %h expected 0", rd2);
        end
    endtask

    task automatic test_random_rw(input int n);
        for (int k = 0; k < n; k++) begin
            we = 1'($urandom); wa = AW'($urandom); wd = $urandom; pc = $urandom;
            ra1 = AW'($urandom); ra2 = (k % 4 == 0) ? wa : AW'($urandom);
            log_ready = 1'($urandom); clear_overflow = 1'b0;
            #1;
            vectors++;
            if (rd1 !== m_read(ra1) || rd2 !== m_read(ra2)) begin
                miscompares++;
                $display("[TB] FAIL rand_read: rd1=%h rd2=%h expected %h %h", rd1, rd2, m_read(ra1), m_read(ra2));
            end
            tick();
            vectors++;
            if (log_valid !== m_valid() || log_count !== 5'(mq.size())) begin
                miscompares++;
                $display("[TB] FAIL rand_fifo: valid=%b count=%0d expected %b %0d", log_valid, log_count, m_valid(), mq.size());
            end
            if (m_valid()) begin
                vectors++;
                if (log_pc !== mq[0].pc || log_addr !== mq[0].addr || log_data !== mq[0].data) begin
                    miscompares++;
                    $display("[TB] FAIL rand_head: %h/%0d/%h expected %h/%0d/%h", log_pc, log_addr, log_data, mq[0].pc, mq[0].addr, mq[0].data);
                end
            end
            vectors++;
            if (log_drops !== 16'(mdrops) || log_overflow !== movf) begin
                miscompares++;
                $display("[TB] FAIL rand_drops: drops=%0d ovf=%b expected %0d %b", log_drops, log_overflow, mdrops, movf);
            end
        end
        we = 1'b0;
    endtask

    task automatic test_drain();
        int k;
        we = 1'b0; clear_overflow = 1'b0; log_ready = 1'b1;
        k = 0;
        while (mq.size() != 0 && k < 200) begin
            vectors++;
            if (log_valid !== m_valid()) begin
                miscompares++;
                $display("[TB] FAIL drain_valid: got %b expected %b", log_valid, m_valid());
            end
            if (m_valid()) begin
                vectors++;
                if (log_pc !== mq[0].pc || log_addr !== mq[0].addr || log_data !== mq[0].data) begin
                    miscompares++;
                    $display("[TB] FAIL drain_head: %h/%0d/%h expected %h/%0d/%h", log_pc, log_addr, log_data, mq[0].pc, mq[0].addr, mq[0].data);
                end
            end
            tick();
            k++;
        end
        vectors++;
        if (mq.size() != 0 || log_count !== 5'd0 || log_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drain_empty: count=%0d valid=%b expected 0 0 (model left %0d)", log_count, log_valid, mq.size());
        end
    endtask

    task automatic test_single_latency();
        int n;
        we = 1'b1; wa = 5'd3; wd = $urandom; pc = 32'h3000; log_ready = 1'b1;
        tick();
        we = 1'b0;
        n = 1;
        while (!log_valid && n < 50) begin
            tick();
            n++;
        end
        vectors++;
        if (n !== DELAY) begin
            miscompares++;
            $display("[TB] FAIL single_latency: valid after %0d cycles expected %0d", n, DELAY);
        end
        vectors++;
        if (log_pc !== 32'h3000 || log_addr !== 5'd3) begin
            miscompares++;
            $display("[TB] FAIL single_head: pc=%h addr=%0d expected 3000 3", log_pc, log_addr);
        end
        tick();
        vectors++;
        if (log_count !== 5'd0 || log_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_pop: count=%0d valid=%b expected 0 0", log_count, log_valid);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] vals [21];
        log_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            we = 1'b1; wa = AW'(i); wd = $urandom; pc = 32'h4000 + 32'(i * 4);
            vals[i] = wd;
            tick();
        end
        we = 1'b0;
        vectors++;
        if (log_count !== 5'd16 || log_drops !== 16'd4 || log_overflow !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL overflow_state: count=%0d drops=%0d ovf=%b expected 16 4 1", log_count, log_drops, log_overflow);
        end
        for (int i = 1; i <= 20; i++) begin
            ra1 = AW'(i);
            #1;
            vectors++;
            if (rd1 !== vals[i]) begin
                miscompares++;
                $display("[TB] FAIL overflow_rf: r%0d got %h expected %h", i, rd1, vals[i]);
            end
            tick();
        end
    endtask

    task automatic test_full_push_pop();
        log_ready = 1'b1; we = 1'b1; wa = 5'd21; wd = $urandom; pc = 32'h5000;
        #1;
        vectors++;
        if (log_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL full_valid: got %b expected 1", log_valid);
        end
        tick();
        we = 1'b0; log_ready = 1'b0;
        vectors++;
        if (log_count !== 5'd16 || log_drops !== 16'd4) begin
            miscompares++;
            $display("[TB] FAIL full_push_pop: count=%0d drops=%0d expected 16 4", log_count, log_drops);
        end
    endtask

    task automatic test_clear_overflow();
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        vectors++;
        if (log_overflow !== 1'b0 || log_drops !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL clear: ovf=%b drops=%0d expected 0 0", log_overflow, log_drops);
        end
        log_ready = 1'b0; we = 1'b1; wa = 5'd22; wd = $urandom; pc = 32'h6000; clear_overflow = 1'b1;
        tick();
        we = 1'b0; clear_overflow = 1'b0;
        vectors++;
        if (log_overflow !== 1'b1 || log_drops !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL clear_vs_drop: ovf=%b drops=%0d expected 1 1", log_overflow, log_drops);
        end
    endtask

    task automatic test_reset_mid();
        log_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            we = 1'b1; wa = AW'(i + 8); wd = $urandom | 32'h1; pc = $urandom;
            tick();
        end
        we = 1'b0; log_ready = 1'b1;
        tick();
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (log_valid !== 1'b0 || log_count !== 5'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: valid=%b count=%0d expected 0 0", log_valid, log_count);
        end
        for (int i = 0; i < 32; i++) begin
            ra1 = AW'(i); ra2 = AW'(31 - i);
            #1;
            vectors++;
            if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
                miscompares++;
                $display("[TB] FAIL async_reset_rf: r%0d rd1=%h rd2=%h expected 0", i, rd1, rd2);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ra1 = '0; ra2 = '0; wa = '0; wd = '0; we = 1'b0; pc = '0;
        log_ready = 1'b0; clear_overflow = 1'b0;
        model_reset();
        test_reset();
        test_bypass_rw();
        test_random_rw(40);
        test_drain();
        test_single_latency();
        test_overflow();
        test_full_push_pop();
        test_clear_overflow();
        test_drain();
        test_reset_mid();
        test_random_rw(60);
        test_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
